alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Single-issue sequencer for the 32-bit ALU.
- Accepts register-addressed instructions over a valid/ready handshake.
- Reads operands from an internal register file and drives the ALU's combinational inputs.
- Waits ALU_LAT cycles, then writes the result and condition flags back.
- Sits between the instruction source and the ALU; it is the control-unit half of the ALU/CU pair.

Parameters:
- DATA_W, 32, operand/result width.
- NREGS, 8, register file depth (power of two).
- AW, 3, register address width = log2(NREGS).
- OP_W, 6, opcode width.
- ALU_LAT, 1, cycles from ALU input drive to result sample (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  controller can accept.
- instr_op  in  OP_W  opcode; class in bits [5:4].
- instr_rd, instr_rs1, instr_rs2  in  AW each  destination and source registers.
- instr_use_c  in  1  drive alu_cin from flag_c; otherwise alu_cin=0.
- ld_valid  in  1  direct register load request.
- ld_addr  in  AW  load target.
- ld_data  in  DATA_W  load value.
- alu_a, alu_b  out  DATA_W  operands to ALU.
- alu_op  out  OP_W  opcode to ALU.
- alu_cin  out  1  carry/borrow-in to ALU.
- alu_ans  in  DATA_W  ALU result.
- alu_ans_opt  in  1  ALU carry/borrow-out or shifted-out bit.
- alu_z, alu_n  in  1 each  ALU zero and negative.
- flag_c, flag_z, flag_n  out  1 each  architectural flags.
- done  out  1  one-cycle pulse on writeback.
- err  out  1  one-cycle pulse on illegal opcode.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  DATA_W  combinational read of regfile[dbg_addr].

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM to IDLE.
  - All registers and flags to 0.
  - done=0, err=0; ALU outputs to 0.
  - Reset overrides any state, including mid-EXEC; the in-flight instruction is dropped with no writeback.
- FSM states:
  - IDLE:
    - instr_ready=1 unless ld_valid=1.
    - ld_valid=1: write ld_data to ld_addr; stay in IDLE. Load has priority over instructions.
    - instr_valid & instr_ready, legal class: latch op, rd, rs1, rs2 and use_c; latch operands regfile[rs1] and regfile[rs2]; go to EXEC; cnt=0.
    - instr_valid & instr_ready, class 00 (illegal): pulse err the next cycle; no ALU drive; no state change; stay in IDLE.
  - EXEC:
    - Drive alu_a, alu_b, alu_op from the latches; alu_cin = use_c & flag_c (flag_c sampled at accept).
    - cnt increments each cycle; at cnt==ALU_LAT-1, sample alu_* into holding registers and go to WB.
    - instr_ready=0; ld_valid is ignored.
  - WB:
    - Write regfile[rd] <= held ans.
    - Flag update by class:
      - 01 arithmetic: C, Z, N all updated.
      - 10 relational: Z, N updated; C held.
      - 11 shift: C, Z, N all updated (C = shifted-out bit).
    - Pulse done; return to IDLE. instr_ready=0 in WB.
- Latency: accept at edge 0, done high in cycle ALU_LAT+1, next accept possible at edge ALU_LAT+2.
- Throughput: one instruction per ALU_LAT+2 cycles.
- Hazards: rd may equal rs1/rs2; operands are latched at accept, so a write never affects its own operands. In-order single issue means no other hazards.
- ALU outputs hold their last values outside EXEC. Flags are visible the cycle after WB.
- Unknown opcodes inside a legal class are passed to the ALU unchanged; result is written as returned.

Decomposition:
- Shared package alu_pkg holds:
  - opcode class constants CLS_ILL=2'b00, CLS_ARI=2'b01, CLS_REL=2'b10, CLS_SHF=2'b11.
  - opcodes OP_ADD=6'b010000, OP_SUB=6'b010001, OP_EQ=6'b100000.
  - FSM state enum {IDLE, EXEC, WB}.
- One sub-module: alu_regfile (NREGS×DATA_W, sync reset, 1 write port, 3 async read ports for rs1, rs2 and dbg).

Test Plan:
- Load r1=5, r2=3; ADD rd=3, rs1=1, rs2=2 -> r3=8; C=0, Z=0, N=0; done exactly ALU_LAT+1 cycles after accept.
- SUB rd=4, rs1=2, rs2=1 -> r4=0xFFFFFFFE, N=1, Z=0.
- Load r5=0xFFFFFFFF, r6=1; ADD rd=7 -> r7=0, C=1, Z=1. Then ADD use_c=1 on r0+r0 -> result 1, C=0.
- Illegal op 6'b000101 -> err pulses once; no done; all regs and flags unchanged; ready back to 1 the next cycle.
- Backpressure: hold instr_valid during EXEC/WB -> ready=0 and nothing accepted; second instruction accepted on the cycle after done. ld_valid together with instr_valid in IDLE -> load wins, instruction waits one cycle.
- Assert rst in EXEC -> no done, regs and flags all 0, FSM in IDLE, ready=1 the cycle after rst drops.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller.
//   - opcode class codes (class lives in the top two opcode bits)
//   - a few named opcodes
//   - controller FSM state type
package alu_pkg;

  localparam logic [1:0] CLS_ILL = 2'b00;
  localparam logic [1:0] CLS_ARI = 2'b01;
  localparam logic [1:0] CLS_REL = 2'b10;
  localparam logic [1:0] CLS_SHF = 2'b11;

  localparam logic [5:0] OP_ADD = 6'b010000;
  localparam logic [5:0] OP_SUB = 6'b010001;
  localparam logic [5:0] OP_EQ  = 6'b100000;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } ctrlState;

  // Relational ops only report Z/N; the carry flag survives them.
  function automatic logic updatesCarry(input logic [1:0] cls);
    return cls != CLS_REL;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU issue controller.
//   clk, rst            : clock, synchronous active-high reset (clears all entries)
//   wrEn/wrAddr/wrData  : single synchronous write port
//   rdAddr1 -> rdData1  : asynchronous read (rs1)
//   rdAddr2 -> rdData2  : asynchronous read (rs2)
//   dbgAddr -> dbgData  : asynchronous read (debug)
module alu_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic [AW-1:0]     wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [AW-1:0]     rdAddr1,
  output logic [DATA_W-1:0] rdData1,
  input  logic [AW-1:0]     rdAddr2,
  output logic [DATA_W-1:0] rdData2,
  input  logic [AW-1:0]     dbgAddr,
  output logic [DATA_W-1:0] dbgData
);

  logic [DATA_W-1:0] regs [NREGS];

  // Reset must clear every entry, so this stays a flop array rather than a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wrEn) begin
      regs[wrAddr] <= wrData;
    end
  end

  assign rdData1 = regs[rdAddr1];
  assign rdData2 = regs[rdAddr2];
  assign dbgData = regs[dbgAddr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue sequencer feeding an external combinational ALU.
//   instr_*        : instruction handshake (valid/ready), opcode, rd/rs1/rs2, use_c
//   ld_*           : direct register load (wins over instructions in IDLE)
//   alu_a/b/op/cin : registered ALU operand drive, held outside EXEC
//   alu_ans/ans_opt/z/n : ALU results, sampled after ALU_LAT cycles
//   flag_c/z/n     : architectural flags, updated on writeback
//   done / err     : one-cycle pulses for writeback / illegal opcode
//   dbg_addr/data  : combinational register file peek
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 8,
  parameter int AW      = 3,
  parameter int OP_W    = 6,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [AW-1:0]     instr_rd,
  input  logic [AW-1:0]     instr_rs1,
  input  logic [AW-1:0]     instr_rs2,
  input  logic              instr_use_c,
  input  logic              ld_valid,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_ans,
  input  logic              alu_ans_opt,
  input  logic              alu_z,
  input  logic              alu_n,
  output logic              flag_c,
  output logic              flag_z,
  output logic              flag_n,
  output logic              done,
  output logic              err,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);

  ctrlState          state;
  logic [CNT_W-1:0]  cnt;
  logic [AW-1:0]     rdLatch;
  logic [1:0]        clsLatch;
  logic [DATA_W-1:0] ansHold;
  logic              cHold;
  logic              zHold;
  logic              nHold;

  logic [DATA_W-1:0] rs1Data;
  logic [DATA_W-1:0] rs2Data;
  logic              wrEn;
  logic [AW-1:0]     wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              accept;
  logic [1:0]        instrCls;

  assign instrCls    = instr_op[OP_W-1 -: 2];
  assign instr_ready = (state == IDLE) && !ld_valid;
  assign accept      = instr_valid && instr_ready;

  // One write port shared by direct loads (IDLE) and writeback (WB);
  // the two never coincide because loads are ignored outside IDLE.
  always_comb begin
    wrEn   = 1'b0;
    wrAddr = ld_addr;
    wrData = ld_data;
    if (state == IDLE && ld_valid) begin
      wrEn = 1'b1;
    end else if (state == WB) begin
      wrEn   = 1'b1;
      wrAddr = rdLatch;
      wrData = ansHold;
    end
  end

  alu_regfile #(
    .DATA_W(DATA_W),
    .NREGS (NREGS),
    .AW    (AW)
  ) uRegfile (
    .clk    (clk),
    .rst    (rst),
    .wrEn   (wrEn),
    .wrAddr (wrAddr),
    .wrData (wrData),
    .rdAddr1(instr_rs1),
    .rdData1(rs1Data),
    .rdAddr2(instr_rs2),
    .rdData2(rs2Data),
    .dbgAddr(dbg_addr),
    .dbgData(dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rdLatch  <= '0;
      clsLatch <= CLS_ILL;
      ansHold  <= '0;
      cHold    <= 1'b0;
      zHold    <= 1'b0;
      nHold    <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      alu_cin  <= 1'b0;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (instrCls == CLS_ILL) begin
              err <= 1'b1;
            end else begin
              // The ALU operand registers double as the operand latches, so
              // a later write to rs1/rs2 cannot disturb this instruction.
              // Carry-in is resolved here, from flag_c as it stands at accept.
              alu_a    <= rs1Data;
              alu_b    <= rs2Data;
              alu_op   <= instr_op;
              alu_cin  <= instr_use_c & flag_c;
              rdLatch  <= instr_rd;
              clsLatch <= instrCls;
              cnt      <= '0;
              state    <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt == CNT_LAST) begin
            ansHold <= alu_ans;
            cHold   <= alu_ans_opt;
            zHold   <= alu_z;
            nHold   <= alu_n;
            state   <= WB;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WB: begin
          if (updatesCarry(clsLatch)) begin
            flag_c <= cHold;
          end
          flag_z <= zHold;
          flag_n <= nHold;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU attached.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int DATA_W  = 32;
  localparam int AW      = 3;
  localparam int OP_W    = 6;
  localparam int ALU_LAT = 1;
  localparam logic [5:0] OP_SHL = 6'b110000;
  localparam logic [5:0] OP_ILL = 6'b000101;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic [OP_W-1:0]   instr_op = '0;
  logic [AW-1:0]     instr_rd = '0;
  logic [AW-1:0]     instr_rs1 = '0;
  logic [AW-1:0]     instr_rs2 = '0;
  logic              instr_use_c = 1'b0;
  logic              ld_valid = 1'b0;
  logic [AW-1:0]     ld_addr = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [OP_W-1:0]   alu_op;
  logic              alu_cin;
  logic [DATA_W-1:0] alu_ans;
  logic              alu_ans_opt, alu_z, alu_n;
  logic              flag_c, flag_z, flag_n;
  logic              done, err;
  logic [AW-1:0]     dbg_addr = '0;
  logic [DATA_W-1:0] dbg_data;

  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] expRegs [8];

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .instr_use_c(instr_use_c),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_ans(alu_ans), .alu_ans_opt(alu_ans_opt), .alu_z(alu_z), .alu_n(alu_n),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n),
    .done(done), .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural ALU: add/sub with carry (sub carry = borrow), EQ returns 1/0,
  // shift class shifts left by one with the top bit as shifted-out bit.
  logic [DATA_W:0] wide;
  always_comb begin
    wide = '0;
    case (alu_op[5:4])
      2'b01: begin
        if (alu_op == OP_SUB) wide = {1'b0, alu_a} - {1'b0, alu_b} - {32'd0, alu_cin};
        else                  wide = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
      end
      2'b10: wide = {1'b0, 31'd0, (alu_a == alu_b)};
      2'b11: wide = {alu_a[DATA_W-1], alu_a[DATA_W-2:0], 1'b0};
      default: wide = '0;
    endcase
  end
  assign alu_ans     = wide[DATA_W-1:0];
  assign alu_ans_opt = wide[DATA_W];
  assign alu_z       = (wide[DATA_W-1:0] == '0);
  assign alu_n       = wide[DATA_W-1];

  // ---------------- driving helpers (no checks inside) ----------------
  task automatic loadReg(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_valid = 1'b0;
    expRegs[a] = d;
  endtask

  // Issues one instruction; lat = cycles from accept edge to observed done, -1 on timeout.
  task automatic issue(input logic [5:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input logic useC, output int lat);
    int w;
    @(negedge clk);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd;
    instr_rs1 = rs1; instr_rs2 = rs2; instr_use_c = useC;
    w = 0;
    while (!instr_ready && w < 20) begin @(negedge clk); w++; end
    @(negedge clk);
    instr_valid = 1'b0; instr_use_c = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    if (!done || w >= 20) lat = -1;
  endtask

  task automatic peek(input logic [AW-1:0] a, output logic [DATA_W-1:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [DATA_W-1:0] d;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) expRegs[i] = '0;
    #1;
    checks++;
    if ({instr_ready, done, err} !== 3'b100) begin
      failures++; $display("FAIL reset_ctrl: ready/done/err=%b expected 100", {instr_ready, done, err});
    end
    checks++;
    if ({flag_c, flag_z, flag_n, alu_cin} !== 4'b0000 || alu_a !== '0 || alu_b !== '0 || alu_op !== '0) begin
      failures++; $display("FAIL reset_outs: flags=%b cin=%b a=%h b=%h op=%h expected all 0",
                           {flag_c, flag_z, flag_n}, alu_cin, alu_a, alu_b, alu_op);
    end
    for (int i = 0; i < 8; i++) begin
      peek(AW'(i), d);
      checks++;
      if (d !== '0) begin failures++; $display("FAIL reset_reg%0d: got %h expected 0", i, d); end
    end
    $display("test_reset done");
  endtask

  task automatic test_add();
    int lat;
    logic [DATA_W-1:0] d;
    loadReg(3'd1, 32'd5);
    loadReg(3'd2, 32'd3);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, lat);
    expRegs[3] = 32'd8;
    checks++;
    if (lat !== ALU_LAT + 1) begin failures++; $display("FAIL add_latency: got %0d expected %0d", lat, ALU_LAT + 1); end
    peek(3'd3, d);
    checks++;
    if (d !== 32'd8) begin failures++; $display("FAIL add_result: got %h expected 00000008", d); end
    checks++;
    if ({flag_c, flag_z, flag_n} !== 3'b000) begin failures++; $display("FAIL add_flags: got %b expected 000", {flag_c, flag_z, flag_n}); end
    checks++;
    if (alu_a !== 32'd5 || alu_b !== 32'd3) begin failures++; $display("FAIL add_hold: a=%h b=%h expected 5/3", alu_a, alu_b); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL add_done_pulse: done=%b expected 0", done); end
    $display("test_add r3=%h lat=%0d", d, lat);
  endtask

  task automatic test_sub();
    int lat;
    logic [DATA_W-1:0] d;
    issue(OP_SUB, 3'd4, 3'd2, 3'd1, 1'b0, lat);
    expRegs[4] = 32'hFFFF_FFFE;
    peek(3'd4, d);
    checks++;
    if (d !== 32'hFFFF_FFFE || lat !== ALU_LAT + 1) begin failures++; $display("FAIL sub_result: got %h lat %0d expected fffffffe lat %0d", d, lat, ALU_LAT + 1); end
    checks++;
    if ({flag_c, flag_z, flag_n} !== 3'b101) begin failures++; $display("FAIL sub_flags: got %b expected 101", {flag_c, flag_z, flag_n}); end
    $display("test_sub r4=%h", d);
  endtask

  task automatic test_carry();
    int lat;
    logic [DATA_W-1:0] d;
    loadReg(3'd5, 32'hFFFF_FFFF);
    loadReg(3'd6, 32'd1);
    issue(OP_ADD, 3'd7, 3'd5, 3'd6, 1'b0, lat);
    expRegs[7] = 32'd0;
    peek(3'd7, d);
    checks++;
    if (d !== 32'd0 || {flag_c, flag_z, flag_n} !== 3'b110) begin
      failures++; $display("FAIL carry_add: got %h flags %b expected 00000000 flags 110", d, {flag_c, flag_z, flag_n});
    end
    // Relational op keeps C from the previous add.
    issue(OP_EQ, 3'd7, 3'd5, 3'd5, 1'b0, lat);
    expRegs[7] = 32'd1;
    peek(3'd7, d);
    checks++;
    if (d !== 32'd1 || {flag_c, flag_z, flag_n} !== 3'b100) begin
      failures++; $display("FAIL rel_keep_c: got %h flags %b expected 00000001 flags 100", d, {flag_c, flag_z, flag_n});
    end
    issue(OP_ADD, 3'd6, 3'd0, 3'd0, 1'b1, lat);
    expRegs[6] = 32'd1;
    peek(3'd6, d);
    checks++;
    if (d !== 32'd1 || alu_cin !== 1'b1 || {flag_c, flag_z, flag_n} !== 3'b000) begin
      failures++; $display("FAIL use_c_add: got %h cin %b flags %b expected 00000001 cin 1 flags 000", d, alu_cin, {flag_c, flag_z, flag_n});
    end
    $display("test_carry r6=%h", d);
  endtask

  task automatic test_shift();
    int lat;
    logic [DATA_W-1:0] d;
    issue(OP_SHL, 3'd1, 3'd5, 3'd0, 1'b0, lat);
    expRegs[1] = 32'hFFFF_FFFE;
    peek(3'd1, d);
    checks++;
    if (d !== 32'hFFFF_FFFE || {flag_c, flag_z, flag_n} !== 3'b101) begin
      failures++; $display("FAIL shift: got %h flags %b expected fffffffe flags 101", d, {flag_c, flag_z, flag_n});
    end
    $display("test_shift r1=%h", d);
  endtask

  task automatic test_illegal();
    logic [DATA_W-1:0] d;
    int doneSeen;
    @(negedge clk);
    instr_valid = 1'b1; instr_op = OP_ILL; instr_rd = 3'd2; instr_rs1 = 3'd1; instr_rs2 = 3'd1;
    @(negedge clk);
    instr_valid = 1'b0;
    checks++;
    if ({err, done, instr_ready} !== 3'b101) begin
      failures++; $display("FAIL illegal_pulse: err/done/ready=%b expected 101", {err, done, instr_ready});
    end
    doneSeen = 0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL illegal_once: err=%b expected 0", err); end
    repeat (3) begin
      if (done) doneSeen++;
      @(negedge clk);
    end
    checks++;
    if (doneSeen != 0) begin failures++; $display("FAIL illegal_no_done: done seen %0d times expected 0", doneSeen); end
    checks++;
    if ({flag_c, flag_z, flag_n} !== 3'b101) begin failures++; $display("FAIL illegal_flags: got %b expected 101", {flag_c, flag_z, flag_n}); end
    for (int i = 0; i < 8; i++) begin
      peek(AW'(i), d);
      checks++;
      if (d !== expRegs[i]) begin failures++; $display("FAIL illegal_reg%0d: got %h expected %h", i, d, expRegs[i]); end
    end
    $display("test_illegal done");
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [DATA_W-1:0] d;
    @(negedge clk);
    instr_valid = 1'b1; instr_op = OP_ADD; instr_rd = 3'd2; instr_rs1 = 3'd2; instr_rs2 = 3'd6;
    @(negedge clk);  // EXEC
    checks++;
    if (instr_ready !== 1'b0) begin failures++; $display("FAIL bp_exec_ready: got %b expected 0", instr_ready); end
    instr_rd = 3'd4; instr_rs1 = 3'd2; instr_rs2 = 3'd2;
    @(negedge clk);  // WB
    checks++;
    if (instr_ready !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL bp_wb: ready/done=%b expected 00", {instr_ready, done}); end
    @(negedge clk);  // first done, second accepted at next edge
    checks++;
    if (done !== 1'b1 || instr_ready !== 1'b1) begin failures++; $display("FAIL bp_first_done: done/ready=%b expected 11", {done, instr_ready}); end
    expRegs[2] = 32'd4;
    @(negedge clk);
    instr_valid = 1'b0;
    checks++;
    if (instr_ready !== 1'b0) begin failures++; $display("FAIL bp_second_accept: ready=%b expected 0", instr_ready); end
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== ALU_LAT + 1) begin failures++; $display("FAIL bp_second_latency: got %0d expected %0d", lat, ALU_LAT + 1); end
    expRegs[4] = 32'd8;
    peek(3'd2, d);
    checks++;
    if (d !== 32'd4) begin failures++; $display("FAIL bp_r2: got %h expected 00000004", d); end
    peek(3'd4, d);
    checks++;
    if (d !== 32'd8 || {flag_c, flag_z, flag_n} !== 3'b000) begin
      failures++; $display("FAIL bp_r4: got %h flags %b expected 00000008 flags 000", d, {flag_c, flag_z, flag_n});
    end
    $display("test_back_to_back r4=%h", d);
  endtask

  task automatic test_load_priority();
    int lat;
    logic [DATA_W-1:0] d;
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 3'd5; ld_data = 32'h10;
    instr_valid = 1'b1; instr_op = OP_ADD; instr_rd = 3'd6; instr_rs1 = 3'd5; instr_rs2 = 3'd5;
    #1;
    checks++;
    if (instr_ready !== 1'b0) begin failures++; $display("FAIL ldprio_ready: got %b expected 0", instr_ready); end
    @(negedge clk);
    ld_valid = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin failures++; $display("FAIL ldprio_wait: ready=%b expected 1", instr_ready); end
    @(negedge clk);
    instr_valid = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    expRegs[5] = 32'h10;
    expRegs[6] = 32'h20;
    peek(3'd6, d);
    checks++;
    if (d !== 32'h20 || lat !== ALU_LAT + 1) begin failures++; $display("FAIL ldprio_result: got %h lat %0d expected 00000020 lat %0d", d, lat, ALU_LAT + 1); end
    $display("test_load_priority r6=%h", d);
  endtask

  task automatic test_reset_mid_exec();
    logic [DATA_W-1:0] d;
    int doneSeen;
    @(negedge clk);
    instr_valid = 1'b1; instr_op = OP_ADD; instr_rd = 3'd7; instr_rs1 = 3'd1; instr_rs2 = 3'd2;
    @(negedge clk);  // EXEC
    instr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({instr_ready, done, flag_c, flag_z, flag_n} !== 5'b10000 || alu_a !== '0) begin
      failures++; $display("FAIL rst_exec_state: ready/done/flags=%b a=%h expected 10000 a=0",
                           {instr_ready, done, flag_c, flag_z, flag_n}, alu_a);
    end
    doneSeen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checks++;
    if (doneSeen != 0) begin failures++; $display("FAIL rst_exec_no_done: done seen %0d expected 0", doneSeen); end
    for (int i = 0; i < 8; i++) begin
      peek(AW'(i), d);
      checks++;
      if (d !== '0) begin failures++; $display("FAIL rst_exec_reg%0d: got %h expected 0", i, d); end
    end
    $display("test_reset_mid_exec done");
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_carry();
    test_shift();
    test_illegal();
    test_back_to_back();
    test_load_priority();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
